sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//  Shares one single-port unified SRAM between the IF fetch port and the EX/MEM data port.
//  Sits between the core pipeline and memory, replacing the separate inst/data SRAM paths.
//  Each cycle it grants at most one requester and returns read data after RD_LAT cycles.
//  It raises a stall request to CTRL while any request is waiting.
// PARAMETERS
//  RD_LAT      1  SRAM read latency in cycles, from mem_en to mem_rdata valid; legal range 1..4
//  STARVE_MAX  3  consecutive lost inst arbitrations before inst is forced to win; 1..15
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   asynchronous reset, active-low
//  inst_req       in   1   fetch request; inst_addr held stable until inst_gnt
//  inst_addr      in   32  fetch byte address
//  inst_gnt       out  1   fetch request accepted this cycle
//  inst_rvalid    out  1   inst_rdata valid
//  inst_rdata     out  32  fetched word
//  data_req       in   1   data request; addr/wen/wdata held stable until data_gnt
//  data_wen       in   4   byte write enables; 0 = read
//  data_addr      in   32  data byte address
//  data_wdata     in   32  store data
//  data_gnt       out  1   data request accepted this cycle
//  data_rvalid    out  1   data_rdata valid; reads only
//  data_rdata     out  32  loaded word
//  mem_en         out  1   SRAM enable
//  mem_wen        out  4   SRAM byte write enables
//  mem_addr       out  32  SRAM address
//  mem_wdata      out  32  SRAM write data
//  mem_rdata      in   32  SRAM read data, valid RD_LAT cycles after mem_en
//  stallreq_mem   out  1   to CTRL: (inst_req & ~inst_gnt) | (data_req & ~data_gnt)
//  conflict_cnt   out  32  arbitration conflict count; see CONFIGURATION
// BEHAVIOUR
//  - Grant logic is combinational in the request cycle.
//    - mem_* carries the winner's fields in that cycle.
//    - With no winner: mem_en=0, mem_wen=0, mem_addr=0, mem_wdata=0.
//  - Priority: data wins by default.
//    - inst wins only when starve_cnt==STARVE_MAX.
//    - A lone requester always wins.
//  - starve_cnt:
//    - +1 on each cycle with inst_req & data_req & data_gnt.
//    - Cleared when inst_gnt=1 or inst_req=0.
//    - Saturates at STARVE_MAX.
//  - Response pipeline: an RD_LAT-deep shift register of tags {valid, src}.
//    - A tag is pushed on every granted read (inst, or data with wen==0).
//    - Writes push an invalid tag.
//    - When a valid tag exits, the matching rvalid pulses for 1 cycle and rdata = mem_rdata.
//    - The other rdata holds its last value.
//  - Back-to-back grants are allowed, so throughput is 1 access per cycle with no bubbles.
//  - Responses return in grant order. inst and data responses never overlap in a cycle.
//  - Write completion is the data_gnt cycle. The write is visible to a read granted the next cycle.
//  - Requester dropping req before gnt is illegal. The arbiter does not check for it.
//  - Reset (asynchronous, any time):
//    - starve_cnt=0 and the tag pipeline is cleared. In-flight reads are dropped, with no rvalid after reset.
//    - All registered outputs are 0: inst_rvalid, data_rvalid, inst_rdata, data_rdata, conflict_cnt.
//    - gnt, mem_* and stallreq_mem are 0 while rst=0.
// CONFIGURATION
//  - Macro SRAM_ARB_PERF_EN defined:
//    - conflict_cnt increments on each cycle with inst_req & data_req.
//    - It wraps 0xFFFFFFFF->0 and resets to 0.
//  - Macro not defined: conflict_cnt is tied to 0 and no counter flops exist.
//  - Arbitration behaviour is identical either way.
// TESTING
//  1. Reset release, inst_req=1 addr 0xBFC00000, RD_LAT=1:
//     -> inst_gnt same cycle, mem_addr=0xBFC00000, mem_wen=0.
//     -> inst_rvalid next cycle with SRAM word.
//  2. data_req write wen=4'hF addr 0x100 data 0xDEADBEEF, then read 0x100 next cycle:
//     -> data_gnt both cycles; data_rvalid 1 cycle after the read grant with 0xDEADBEEF.
//     -> no rvalid for the write.
//  3. inst_req and data_req both held high for 8 cycles, STARVE_MAX=3:
//     -> grant pattern D,D,D,I repeating.
//     -> stallreq_mem=1 on every cycle.
//     -> conflict_cnt=8 with SRAM_ARB_PERF_EN, 0 without.
//  4. RD_LAT=3, alternating I/D reads each cycle:
//     -> rvalids return 3 cycles after each grant in order, one per cycle.
//     -> correct src routing, never both asserted.
//  5. Assert rst=0 with 2 reads in flight (RD_LAT=3):
//     -> all outputs 0 immediately.
//     -> no rvalid after release; starve_cnt restarts at 0.
//  6. Force conflict_cnt to 0xFFFFFFFF (PERF_EN) plus one conflict cycle -> wraps to 0.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port SRAM between the fetch and data ports.
// Defining SRAM_ARB_PERF_EN adds the arbitration conflict counter on conflict_cnt.
module sram_port_arbiter #(
   parameter int unsigned RD_LAT     = 1,
   parameter int unsigned STARVE_MAX = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_gnt,
   output logic        inst_rvalid,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic [3:0]  data_wen,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_gnt,
   output logic        data_rvalid,
   output logic [31:0] data_rdata,
   output logic        mem_en,
   output logic [3:0]  mem_wen,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        stallreq_mem,
   output logic [31:0] conflict_cnt
);

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned DATA_W = 32;

   logic [CNT_W-1:0]  starve_cnt, starve_nxt;
   logic              starve_full;
   logic              push_i, push_d;
   logic [RD_LAT-1:0] tag_i_q, tag_d_q, tag_i_nxt, tag_d_nxt;
   logic [DATA_W-1:0] inst_rdata_q, data_rdata_q;

   // Data wins unless fetch has lost STARVE_MAX arbitrations in a row; nothing is granted in reset.
   assign starve_full  = (starve_cnt == CNT_W'(STARVE_MAX));
   assign inst_gnt     = rst & inst_req & (~data_req | starve_full);
   assign data_gnt     = rst & data_req & ~inst_gnt;
   assign stallreq_mem = rst & ((inst_req & ~inst_gnt) | (data_req & ~data_gnt));

   assign push_i = inst_gnt;
   assign push_d = data_gnt & (data_wen == 4'h0);

   always_comb begin
      mem_en    = 1'b0;
      mem_wen   = 4'h0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (inst_gnt) begin
         mem_en   = 1'b1;
         mem_addr = inst_addr;
      end else if (data_gnt) begin
         mem_en    = 1'b1;
         mem_wen   = data_wen;
         mem_addr  = data_addr;
         mem_wdata = data_wdata;
      end
   end

   always_comb begin
      starve_nxt = starve_cnt;
      if (!inst_req || inst_gnt) begin
         starve_nxt = '0;
      end else if (data_gnt && !starve_full) begin
         starve_nxt = starve_cnt + CNT_W'(1);
      end
   end

   // Read tags travel RD_LAT stages so each one exits in the cycle its SRAM word arrives.
   always_comb begin
      tag_i_nxt    = '0;
      tag_d_nxt    = '0;
      tag_i_nxt[0] = push_i;
      tag_d_nxt[0] = push_d;
      for (int i = 1; i < int'(RD_LAT); i++) begin
         tag_i_nxt[i] = tag_i_q[i-1];
         tag_d_nxt[i] = tag_d_q[i-1];
      end
   end

   assign inst_rvalid = tag_i_q[RD_LAT-1];
   assign data_rvalid = tag_d_q[RD_LAT-1];
   assign inst_rdata  = inst_rvalid ? mem_rdata : inst_rdata_q;
   assign data_rdata  = data_rvalid ? mem_rdata : data_rdata_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt   <= '0;
         tag_i_q      <= '0;
         tag_d_q      <= '0;
         inst_rdata_q <= '0;
         data_rdata_q <= '0;
      end else begin
         starve_cnt <= starve_nxt;
         tag_i_q    <= tag_i_nxt;
         tag_d_q    <= tag_d_nxt;
         if (inst_rvalid) inst_rdata_q <= mem_rdata;
         if (data_rvalid) data_rdata_q <= mem_rdata;
      end
   end

`ifdef SRAM_ARB_PERF_EN
   logic [DATA_W-1:0] conflict_q;

   // Counts cycles where both ports request; wraps naturally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         conflict_q <= '0;
      end else if (inst_req && data_req) begin
         conflict_q <= conflict_q + DATA_W'(1);
      end
   end

   assign conflict_cnt = conflict_q;
`else
   assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: one instance at RD_LAT=1 and one at RD_LAT=3,
// each backed by its own behavioural SRAM whose unwritten words read as 0xC0DE0000 + word index.
module tb_sram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        inst_req = 1'b0;
   logic [31:0] inst_addr = '0;
   logic        data_req = 1'b0;
   logic [3:0]  data_wen = '0;
   logic [31:0] data_addr = '0;
   logic [31:0] data_wdata = '0;

   logic        u1_inst_gnt, u1_inst_rvalid, u1_data_gnt, u1_data_rvalid, u1_mem_en, u1_stall;
   logic [31:0] u1_inst_rdata, u1_data_rdata, u1_mem_addr, u1_mem_wdata, u1_conflict;
   logic [3:0]  u1_mem_wen;
   logic [31:0] rd1;
   logic        u3_inst_gnt, u3_inst_rvalid, u3_data_gnt, u3_data_rvalid, u3_mem_en, u3_stall;
   logic [31:0] u3_inst_rdata, u3_data_rdata, u3_mem_addr, u3_mem_wdata, u3_conflict;
   logic [3:0]  u3_mem_wen;
   logic [31:0] rd3, rd3_p, rd3_q;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sram_port_arbiter #(.RD_LAT(1), .STARVE_MAX(3)) u_dut1 (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(u1_inst_gnt),
      .inst_rvalid(u1_inst_rvalid), .inst_rdata(u1_inst_rdata),
      .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_gnt(u1_data_gnt), .data_rvalid(u1_data_rvalid), .data_rdata(u1_data_rdata),
      .mem_en(u1_mem_en), .mem_wen(u1_mem_wen), .mem_addr(u1_mem_addr), .mem_wdata(u1_mem_wdata),
      .mem_rdata(rd1), .stallreq_mem(u1_stall), .conflict_cnt(u1_conflict)
   );

   sram_port_arbiter #(.RD_LAT(3), .STARVE_MAX(3)) u_dut3 (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(u3_inst_gnt),
      .inst_rvalid(u3_inst_rvalid), .inst_rdata(u3_inst_rdata),
      .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_gnt(u3_data_gnt), .data_rvalid(u3_data_rvalid), .data_rdata(u3_data_rdata),
      .mem_en(u3_mem_en), .mem_wen(u3_mem_wen), .mem_addr(u3_mem_addr), .mem_wdata(u3_mem_wdata),
      .mem_rdata(rd3), .stallreq_mem(u3_stall), .conflict_cnt(u3_conflict)
   );

   // Behavioural SRAMs: writes land at the enable edge, reads return after 1 or 3 edges.
   logic [31:0] mem1 [int unsigned];
   logic [31:0] mem3 [int unsigned];
   int unsigned idx1, idx3;
   logic [31:0] w1, w3;

   always @(posedge clk) begin
      if (u1_mem_en) begin
         idx1 = 32'(u1_mem_addr[11:2]);
         w1 = mem1.exists(idx1) ? mem1[idx1] : 32'hC0DE_0000 + idx1;
         if (u1_mem_wen != 4'h0) begin
            for (int b = 0; b < 4; b++) if (u1_mem_wen[b]) w1[8*b +: 8] = u1_mem_wdata[8*b +: 8];
            mem1[idx1] = w1;
         end else begin
            rd1 <= w1;
         end
      end
   end

   always @(posedge clk) begin
      if (u3_mem_en) begin
         idx3 = 32'(u3_mem_addr[11:2]);
         w3 = mem3.exists(idx3) ? mem3[idx3] : 32'hC0DE_0000 + idx3;
         if (u3_mem_wen != 4'h0) begin
            for (int b = 0; b < 4; b++) if (u3_mem_wen[b]) w3[8*b +: 8] = u3_mem_wdata[8*b +: 8];
            mem3[idx3] = w3;
         end else begin
            rd3_p <= w3;
         end
      end
      rd3_q <= rd3_p;
      rd3   <= rd3_q;
   end

   // Drive one cycle of requests at the falling edge, then settle before checking.
   task automatic cyc(input logic ir, input logic [31:0] ia, input logic dr,
                      input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd);
      @(negedge clk);
      inst_req = ir; inst_addr = ia;
      data_req = dr; data_wen = dw; data_addr = da; data_wdata = dd;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   task automatic test_reset;
      inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
      #1;
      n_checks++; if (u1_inst_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_inst_gnt: got %b want 0", u1_inst_gnt); end
      n_checks++; if (u1_mem_en !== 1'b0) begin n_fail++; $display("FAIL rst_mem_en: got %b want 0", u1_mem_en); end
      n_checks++; if (u1_mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr: got %h want 0", u1_mem_addr); end
      n_checks++; if (u1_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", u1_stall); end
      n_checks++; if ({u1_inst_rvalid, u1_data_rvalid} !== 2'b00) begin n_fail++; $display("FAIL rst_rvalid: got %b want 00", {u1_inst_rvalid, u1_data_rvalid}); end
      n_checks++; if (u1_inst_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_inst_rdata: got %h want 0", u1_inst_rdata); end
      n_checks++; if (u1_data_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_data_rdata: got %h want 0", u1_data_rdata); end
      n_checks++; if (u1_conflict !== 32'h0) begin n_fail++; $display("FAIL rst_conflict: got %h want 0", u1_conflict); end
      @(negedge clk); @(negedge clk);
   endtask

   task automatic test_fetch_after_reset;
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++; if (u1_inst_gnt !== 1'b1) begin n_fail++; $display("FAIL t1_inst_gnt: got %b want 1", u1_inst_gnt); end
      n_checks++; if (u1_mem_addr !== 32'hBFC0_0000) begin n_fail++; $display("FAIL t1_mem_addr: got %h want bfc00000", u1_mem_addr); end
      n_checks++; if (u1_mem_wen !== 4'h0) begin n_fail++; $display("FAIL t1_mem_wen: got %h want 0", u1_mem_wen); end
      n_checks++; if (u1_mem_en !== 1'b1) begin n_fail++; $display("FAIL t1_mem_en: got %b want 1", u1_mem_en); end
      n_checks++; if (u1_stall !== 1'b0) begin n_fail++; $display("FAIL t1_stall: got %b want 0", u1_stall); end
      idle(1);
      n_checks++; if (u1_inst_rvalid !== 1'b1) begin n_fail++; $display("FAIL t1_inst_rvalid: got %b want 1", u1_inst_rvalid); end
      n_checks++; if (u1_inst_rdata !== 32'hC0DE_0000) begin n_fail++; $display("FAIL t1_inst_rdata: got %h want c0de0000", u1_inst_rdata); end
      n_checks++; if (u1_data_rvalid !== 1'b0) begin n_fail++; $display("FAIL t1_data_rvalid: got %b want 0", u1_data_rvalid); end
      idle(1);
      n_checks++; if (u1_inst_rvalid !== 1'b0) begin n_fail++; $display("FAIL t1_rvalid_pulse: got %b want 0", u1_inst_rvalid); end
      n_checks++; if (u1_inst_rdata !== 32'hC0DE_0000) begin n_fail++; $display("FAIL t1_rdata_hold: got %h want c0de0000", u1_inst_rdata); end
      idle(4);
   endtask

   task automatic test_write_then_read;
      cyc(1'b0, 32'h0, 1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF);
      n_checks++; if (u1_data_gnt !== 1'b1) begin n_fail++; $display("FAIL t2_wr_gnt: got %b want 1", u1_data_gnt); end
      n_checks++; if (u1_mem_wen !== 4'hF) begin n_fail++; $display("FAIL t2_mem_wen: got %h want f", u1_mem_wen); end
      n_checks++; if (u1_mem_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL t2_mem_wdata: got %h want deadbeef", u1_mem_wdata); end
      cyc(1'b0, 32'h0, 1'b1, 4'h0, 32'h100, 32'h0);
      n_checks++; if (u1_data_gnt !== 1'b1) begin n_fail++; $display("FAIL t2_rd_gnt: got %b want 1", u1_data_gnt); end
      n_checks++; if (u1_data_rvalid !== 1'b0) begin n_fail++; $display("FAIL t2_wr_rvalid: got %b want 0", u1_data_rvalid); end
      idle(1);
      n_checks++; if (u1_data_rvalid !== 1'b1) begin n_fail++; $display("FAIL t2_rd_rvalid: got %b want 1", u1_data_rvalid); end
      n_checks++; if (u1_data_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL t2_rd_rdata: got %h want deadbeef", u1_data_rdata); end
      n_checks++; if (u1_inst_rvalid !== 1'b0) begin n_fail++; $display("FAIL t2_inst_rvalid: got %b want 0", u1_inst_rvalid); end
      idle(4);
   endtask

   task automatic test_starvation;
      logic        exp_d;
      logic [31:0] exp_cc;
      for (int k = 0; k < 8; k++) begin
         cyc(1'b1, 32'h200, 1'b1, 4'h0, 32'h300, 32'h0);
         exp_d = ((k % 4) != 3);
         n_checks++; if (u1_data_gnt !== exp_d) begin n_fail++; $display("FAIL t3_data_gnt[%0d]: got %b want %b", k, u1_data_gnt, exp_d); end
         n_checks++; if (u1_inst_gnt !== !exp_d) begin n_fail++; $display("FAIL t3_inst_gnt[%0d]: got %b want %b", k, u1_inst_gnt, !exp_d); end
         n_checks++; if (u1_stall !== 1'b1) begin n_fail++; $display("FAIL t3_stall[%0d]: got %b want 1", k, u1_stall); end
         n_checks++; if (u1_mem_addr !== (exp_d ? 32'h300 : 32'h200)) begin n_fail++; $display("FAIL t3_mem_addr[%0d]: got %h want %h", k, u1_mem_addr, exp_d ? 32'h300 : 32'h200); end
      end
      idle(1);
`ifdef SRAM_ARB_PERF_EN
      exp_cc = 32'd8;
`else
      exp_cc = 32'd0;
`endif
      n_checks++; if (u1_conflict !== exp_cc) begin n_fail++; $display("FAIL t3_conflict: got %0d want %0d", u1_conflict, exp_cc); end
      idle(4);
   endtask

   task automatic test_back_to_back;
      logic        exp_i, exp_d;
      logic [31:0] exp_w;
      for (int c = 0; c < 10; c++) begin
         if (c < 6 && (c % 2) == 0) cyc(1'b1, 32'h400 + 32'(4*c), 1'b0, 4'h0, 32'h0, 32'h0);
         else if (c < 6)            cyc(1'b0, 32'h0, 1'b1, 4'h0, 32'h400 + 32'(4*c), 32'h0);
         else                       idle(1);
         if (c < 6) begin
            n_checks++; if ((u3_inst_gnt | u3_data_gnt) !== 1'b1) begin n_fail++; $display("FAIL t4_gnt[%0d]: got %b want 1", c, u3_inst_gnt | u3_data_gnt); end
         end
         exp_i = (c >= 3 && c <= 8 && ((c - 3) % 2) == 0);
         exp_d = (c >= 3 && c <= 8 && ((c - 3) % 2) == 1);
         exp_w = 32'hC0DE_0100 + 32'(c - 3);
         n_checks++; if (u3_inst_rvalid !== exp_i) begin n_fail++; $display("FAIL t4_inst_rvalid[%0d]: got %b want %b", c, u3_inst_rvalid, exp_i); end
         n_checks++; if (u3_data_rvalid !== exp_d) begin n_fail++; $display("FAIL t4_data_rvalid[%0d]: got %b want %b", c, u3_data_rvalid, exp_d); end
         if (exp_i) begin
            n_checks++; if (u3_inst_rdata !== exp_w) begin n_fail++; $display("FAIL t4_inst_rdata[%0d]: got %h want %h", c, u3_inst_rdata, exp_w); end
         end
         if (exp_d) begin
            n_checks++; if (u3_data_rdata !== exp_w) begin n_fail++; $display("FAIL t4_data_rdata[%0d]: got %h want %h", c, u3_data_rdata, exp_w); end
         end
      end
      idle(4);
   endtask

   task automatic test_reset_in_flight;
      logic exp_d;
      for (int k = 0; k < 2; k++) begin
         cyc(1'b1, 32'h500, 1'b1, 4'h0, 32'h504, 32'h0);
         n_checks++; if (u3_data_gnt !== 1'b1) begin n_fail++; $display("FAIL t5_pre_gnt[%0d]: got %b want 1", k, u3_data_gnt); end
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++; if ({u3_inst_gnt, u3_data_gnt} !== 2'b00) begin n_fail++; $display("FAIL t5_gnt: got %b want 00", {u3_inst_gnt, u3_data_gnt}); end
      n_checks++; if ({u3_mem_en, u3_stall} !== 2'b00) begin n_fail++; $display("FAIL t5_en_stall: got %b want 00", {u3_mem_en, u3_stall}); end
      n_checks++; if (u3_mem_addr !== 32'h0) begin n_fail++; $display("FAIL t5_mem_addr: got %h want 0", u3_mem_addr); end
      n_checks++; if (u3_data_rdata !== 32'h0) begin n_fail++; $display("FAIL t5_data_rdata: got %h want 0", u3_data_rdata); end
      n_checks++; if (u3_inst_rdata !== 32'h0) begin n_fail++; $display("FAIL t5_inst_rdata: got %h want 0", u3_inst_rdata); end
      n_checks++; if (u3_conflict !== 32'h0) begin n_fail++; $display("FAIL t5_conflict: got %h want 0", u3_conflict); end
      @(negedge clk);
      rst = 1'b1; inst_req = 1'b0; data_req = 1'b0;
      #1;
      n_checks++; if ({u3_inst_rvalid, u3_data_rvalid} !== 2'b00) begin n_fail++; $display("FAIL t5_rvalid_rel: got %b want 00", {u3_inst_rvalid, u3_data_rvalid}); end
      for (int k = 0; k < 3; k++) begin
         idle(1);
         n_checks++; if ({u3_inst_rvalid, u3_data_rvalid} !== 2'b00) begin n_fail++; $display("FAIL t5_rvalid_after[%0d]: got %b want 00", k, {u3_inst_rvalid, u3_data_rvalid}); end
      end
      for (int k = 0; k < 4; k++) begin
         cyc(1'b1, 32'h500, 1'b1, 4'h0, 32'h504, 32'h0);
         exp_d = (k != 3);
         n_checks++; if (u3_data_gnt !== exp_d) begin n_fail++; $display("FAIL t5_starve[%0d]: got %b want %b", k, u3_data_gnt, exp_d); end
      end
      idle(4);
   endtask

`ifdef SRAM_ARB_PERF_EN
   task automatic test_conflict_wrap;
      @(negedge clk);
      force u_dut1.conflict_q = 32'hFFFF_FFFF;
      #1;
      release u_dut1.conflict_q;
      inst_req = 1'b1; data_req = 1'b1; data_wen = 4'h0;
      idle(1);
      n_checks++; if (u1_conflict !== 32'h0) begin n_fail++; $display("FAIL t6_wrap: got %h want 0", u1_conflict); end
      idle(4);
   endtask
`endif

   initial begin
      test_reset();
      test_fetch_after_reset();
      test_write_then_read();
      test_starvation();
      test_back_to_back();
      test_reset_in_flight();
`ifdef SRAM_ARB_PERF_EN
      test_conflict_wrap();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
